sign_mag_to_bcd: RTL and testbench
==================================

# sign_mag_to_bcd

Sequential binary-to-BCD converter that sits directly downstream of the operand/result selector in the VGA calculator display path. It takes the 33-bit sign-magnitude word produced for the display (bit 32 = sign, bits 31:0 = magnitude) and converts the magnitude into ten packed BCD digits using shift-add-3 (double-dabble), one bit per clock. It also reports the sign and the significant-digit count to the character renderer. Results are held stable between conversions, so the renderer never sees a partially converted value.

## Interface

Parameters: none. The digit count is fixed at 10, which covers 2^32-1 = 4294967295.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `num_in`  in  33  sign-magnitude operand; bit 32 = negative flag, bits 31:0 = unsigned magnitude.
- `start`  in  1  conversion request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until FINISH completes.
- `done`  out  1  one-cycle pulse when new results are valid.
- `bcd`  out  40  packed BCD; `bcd[3:0]` = units, `bcd[39:36]` = 10^9 digit.
- `neg`  out  1  display minus sign.
- `ndigits`  out  4  number of significant digits, 1..10. The value 0 reports 1.

## Operation

States: IDLE, SHIFT, FINISH.

- **IDLE**
  - On a rising edge with start=1: latch `num_in[31:0]` into a 32-bit shift register and `num_in[32]` into a sign register.
  - Clear the 40-bit BCD accumulator and bit counter, then go to SHIFT.
- **SHIFT** (32 edges, counter 0..31). Each edge:
  1. For every nibble of the accumulator ≥ 5, add 3 (all ten nibbles evaluated in parallel, combinationally).
  2. Shift {accumulator, shift register} left by one; the shift-register MSB enters accumulator bit 0.
  3. Increment the counter. On the edge where the counter = 31, go to FINISH.
- **FINISH** (one edge):
  - Copy the accumulator to `bcd`.
  - Set `ndigits` = index of the highest nonzero nibble + 1, or 1 if all nibbles are zero.
  - Set `neg` = sign register AND (magnitude ≠ 0). Negative zero displays as positive.
  - Assert `done` and go to IDLE.
- **Output stability**
  - `bcd`, `neg` and `ndigits` change only on the FINISH edge.
  - They hold their previous values throughout SHIFT.
- **Ignored inputs**
  - `start` is ignored in SHIFT and FINISH; the request is not queued.
  - Changes to `num_in` after the accept edge do not affect the conversion in progress.
- **Width rule**
  - The magnitude is treated as unsigned 32-bit.
  - 0x8000_0000 with sign set converts to 2147483648, neg=1.
- **Reset** (`rst_n`=0, at any time, including mid-conversion):
  - State IDLE, counter 0, shift register and accumulator 0.
  - Outputs: `bcd`=0, `ndigits`=1, `neg`=0, `busy`=0, `done`=0.
  - No `done` pulse is produced for an aborted conversion.

## Timing

- Edge E0: start=1 sampled in IDLE.
- Edges E1..E32: the 32 shift steps; `busy`=1 from after E0 through E33.
- Edge E33: FINISH. `bcd`/`neg`/`ndigits` update, `done`=1 for exactly the cycle after E33, and `busy` returns to 0 after E33.
- Latency: 34 clocks from start sample to the done cycle; throughput is one conversion per 34 clocks.
- Start held high continuously gives back-to-back conversions; the next accept edge is E34, the edge ending the done cycle.
- `done` and `busy` are registered outputs with no combinational path from `start`.
- Reset assertion is asynchronous; release is synchronised externally and the block does not re-synchronise it.

## Test plan

- **Reset:** assert `rst_n`=0 mid-SHIFT, release → `bcd`=40'h0, `ndigits`=1, `neg`=0, `busy`=0; no `done` for 40 cycles.
- **Zero:** `num_in`=33'h0_0000_0000, pulse start → `done` on the 34th cycle; `bcd`=0, `ndigits`=1, `neg`=0.
- **Small negative and negative zero:**
  - `num_in`=33'h1_0000_007B → `bcd`=40'h00_0000_0123, `ndigits`=3, `neg`=1.
  - `num_in`=33'h1_0000_0000 → `neg`=0, `ndigits`=1.
- **Extremes:**
  - 33'h1_8000_0000 → `bcd`=40'h21_4748_3648, `ndigits`=10, `neg`=1.
  - 33'h0_FFFF_FFFF → `bcd`=40'h42_9496_7295, `ndigits`=10, `neg`=0.
- **Mid-conversion activity:** start 33'h0_0000_04D2 (1234), then change `num_in` to 33'h0_0000_0009 and pulse start at E10 → result `bcd`=40'h1234, single `done`, and `bcd` holds its old value at E1..E32.
- **Back-to-back:** start held high with 100, then 99999 → two `done` pulses 34 cycles apart, `ndigits` 3 then 5.

Source files
------------

// File: rtl/sign_mag_to_bcd.sv
// sign_mag_to_bcd
// Converts a 33-bit sign-magnitude display word into ten packed BCD digits
// using shift-add-3 (double-dabble), one magnitude bit per clock. The sign and
// the count of significant digits are reported alongside the digits. All
// results are registered and change only when a conversion finishes, so the
// character renderer never sees a half-converted value.

module sign_mag_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [32:0] num_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd,
  output logic        neg,
  output logic [3:0]  ndigits
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t      r_state;
  logic [31:0] r_shift;
  logic        r_sign;
  logic [39:0] r_acc;
  logic [4:0]  r_count;

  logic        r_busy;
  logic        r_done;
  logic [39:0] r_bcd;
  logic        r_neg;
  logic [3:0]  r_ndigits;

  logic [39:0] w_adj;
  logic [3:0]  w_ndigits;

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd     = r_bcd;
  assign neg     = r_neg;
  assign ndigits = r_ndigits;

  // Add-3 correction: every nibble of 5 or more is pre-adjusted in parallel
  // so that the following left shift carries correctly into the next digit.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 10; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Significant-digit count: position of the highest nonzero nibble plus one,
  // with an all-zero accumulator still reporting a single digit.
  always_comb begin
    w_ndigits = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (r_acc[4*i +: 4] != 4'd0) begin
        w_ndigits = 4'(i + 1);
      end
    end
  end

  // Conversion sequencer: accept in IDLE, 32 shift steps, then publish results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= 32'd0;
      r_sign    <= 1'b0;
      r_acc     <= 40'd0;
      r_count   <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= 40'd0;
      r_neg     <= 1'b0;
      r_ndigits <= 4'd1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= num_in[31:0];
            r_sign  <= num_in[32];
            r_acc   <= 40'd0;
            r_count <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_acc, r_shift} <= {w_adj[38:0], r_shift, 1'b0};
          r_count          <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_bcd     <= r_acc;
          r_ndigits <= w_ndigits;
          r_neg     <= r_sign && (r_acc != 40'd0);
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// tb_sign_mag_to_bcd
// Self-checking bench for sign_mag_to_bcd. Expected digits come from a
// decimal reference model built on plain division by ten.

module tb_sign_mag_to_bcd;

  logic        clk;
  logic        rst_n;
  logic [32:0] num_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic        neg;
  logic [3:0]  ndigits;

  int nCompared   = 0;
  int nMismatched = 0;

  sign_mag_to_bcd dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .num_in  (num_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .neg     (neg),
    .ndigits (ndigits)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference BCD: peel decimal digits off the magnitude one at a time.
  function automatic logic [39:0] refBcd(input logic [31:0] mag);
    logic [39:0] r;
    longint      v;
    r = 40'd0;
    v = longint'(mag);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference digit count: how many times the value can be divided by ten.
  function automatic logic [3:0] refNdigits(input logic [31:0] mag);
    longint v;
    int     d;
    v = longint'(mag);
    d = 1;
    while (v >= 10) begin
      v = v / 10;
      d++;
    end
    return 4'(d);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done after the accept edge; returns edges counted (capped).
  task automatic waitDone(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 60);
  endtask

  // Drives one full conversion with a single-cycle start and checks everything.
  task automatic applyStimulus(input string tag, input logic [32:0] val);
    int          edges;
    logic [39:0] expBcd;
    @(negedge clk);
    num_in = val;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    waitDone(edges);
    expBcd = refBcd(val[31:0]);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd33);
    checkOutput({tag, "_bcd"}, 64'(bcd), 64'(expBcd));
    checkOutput({tag, "_ndigits"}, 64'(ndigits), 64'(refNdigits(val[31:0])));
    checkOutput({tag, "_neg"}, 64'(neg), 64'(val[32] && (val[31:0] != 32'd0)));
    @(posedge clk);
    #1;
    checkOutput({tag, "_donepulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_idlebusy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          edges;
    int          edges2;
    bit          sawDone;
    bit          heldOk;
    logic [39:0] oldBcd;
    logic [32:0] rv;

    rst_n  = 1'b0;
    start  = 1'b0;
    num_in = 33'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bcd", 64'(bcd), 64'd0);
    checkOutput("rst_ndigits", 64'(ndigits), 64'd1);
    checkOutput("rst_neg", 64'(neg), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("zero", 33'h0_0000_0000);
    checkOutput("zero_bcd_const", 64'(bcd), 64'h0);
    applyStimulus("neg123", 33'h1_0000_007B);
    checkOutput("neg123_bcd_const", 64'(bcd), 64'h00_0000_0123);
    applyStimulus("negzero", 33'h1_0000_0000);
    checkOutput("negzero_neg_const", 64'(neg), 64'd0);
    applyStimulus("minint", 33'h1_8000_0000);
    checkOutput("minint_bcd_const", 64'(bcd), 64'h21_4748_3648);
    applyStimulus("maxu32", 33'h0_FFFF_FFFF);
    checkOutput("maxu32_bcd_const", 64'(bcd), 64'h42_9496_7295);

    // Mid-conversion input changes and a stray start must be ignored.
    oldBcd = bcd;
    @(negedge clk);
    num_in = 33'h0_0000_04D2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    num_in = 33'h0_0000_0009;
    edges  = 0;
    heldOk = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 9) start = 1'b1;
      if (edges == 10) start = 1'b0;
      if (!done && bcd !== oldBcd) heldOk = 1'b0;
    end while (!done && edges < 60);
    checkOutput("mid_hold", 64'(heldOk), 64'd1);
    checkOutput("mid_latency", 64'(edges), 64'd33);
    checkOutput("mid_bcd", 64'(bcd), 64'h1234);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("mid_singledone", 64'(sawDone), 64'd0);

    // Reset mid-SHIFT aborts the conversion without a done pulse.
    @(negedge clk);
    num_in = 33'h1_0001_E240;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_bcd", 64'(bcd), 64'd0);
    checkOutput("abort_ndigits", 64'(ndigits), 64'd1);
    checkOutput("abort_neg", 64'(neg), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", 64'(sawDone), 64'd0);

    // Back-to-back conversions with start held high.
    @(negedge clk);
    num_in = 33'd100;
    start  = 1'b1;
    @(posedge clk);
    #1;
    num_in = 33'd99999;
    waitDone(edges);
    checkOutput("b2b_lat1", 64'(edges), 64'd33);
    checkOutput("b2b_nd1", 64'(ndigits), 64'd3);
    checkOutput("b2b_bcd1", 64'(bcd), 64'h100);
    waitDone(edges2);
    start = 1'b0;
    checkOutput("b2b_gap", 64'(edges2), 64'd34);
    checkOutput("b2b_nd2", 64'(ndigits), 64'd5);
    checkOutput("b2b_bcd2", 64'(bcd), 64'h99999);
    @(posedge clk);
    #1;
    checkOutput("b2b_stop", 64'(busy), 64'd0);

    // Randomised magnitudes spread across all digit counts.
    for (int k = 0; k < 24; k++) begin
      rv[31:0] = $urandom() >> $urandom_range(0, 31);
      rv[32]   = 1'($urandom_range(0, 1));
      applyStimulus("rand", rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
